pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 126 ++++++++++++
 tb/tb_pipe_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall controller: per-stage load enables and bubble inserts,
// halt drain sequencing and a saturating count of PC-stall cycles.
//
// state  | meaning
// RUN    | normal issue; hazards resolved by priority
// DRAIN  | halt accepted; fetch frozen while 3 live stages flush out
// HALTED | pipeline empty and stopped; only rst leaves
module pipe_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_use,
    input  logic        br_taken,
    input  logic        imem_stall,
    input  logic        dmem_stall,
    input  logic        halt,
    output logic        pc_en,
    output logic        fd_en,
    output logic        de_en,
    output logic        em_en,
    output logic        mw_en,
    output logic        fd_nop,
    output logic        de_nop,
    output logic        em_nop,
    output logic        mw_nop,
    output logic        halted,
    output logic [15:0] stall_cnt
);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    state_t     state, state_nxt;
    logic [1:0] drain_cnt, drain_nxt;

    always_comb begin
        pc_en     = 1'b1;
        fd_en     = 1'b1;
        de_en     = 1'b1;
        em_en     = 1'b1;
        mw_en     = 1'b1;
        fd_nop    = 1'b0;
        de_nop    = 1'b0;
        em_nop    = 1'b0;
        mw_nop    = 1'b0;
        halted    = 1'b0;
        state_nxt = state;
        drain_nxt = drain_cnt;

        case (state)
            RUN: begin
                if (dmem_stall) begin
                    pc_en  = 1'b0;
                    fd_en  = 1'b0;
                    de_en  = 1'b0;
                    em_en  = 1'b0;
                    mw_nop = 1'b1;
                end else if (br_taken) begin
                    fd_nop = 1'b1;
                    de_nop = 1'b1;
                end else if (load_use) begin
                    pc_en  = 1'b0;
                    fd_en  = 1'b0;
                    de_nop = 1'b1;
                end else if (imem_stall) begin
                    pc_en  = 1'b0;
                    fd_nop = 1'b1;
                end
                // A halt behind a taken branch is flushed; stalls just defer it.
                if (halt && !dmem_stall && !br_taken && !load_use) begin
                    state_nxt = DRAIN;
                    drain_nxt = 2'd3;
                end
            end
            DRAIN: begin
                if (dmem_stall) begin
                    pc_en  = 1'b0;
                    fd_en  = 1'b0;
                    de_en  = 1'b0;
                    em_en  = 1'b0;
                    mw_nop = 1'b1;
                end else begin
                    pc_en     = 1'b0;
                    fd_nop    = 1'b1;
                    drain_nxt = drain_cnt - 2'd1;
                    if (drain_cnt == 2'd1) state_nxt = HALTED;
                end
            end
            HALTED: begin
                pc_en  = 1'b0;
                fd_en  = 1'b0;
                de_en  = 1'b0;
                em_en  = 1'b0;
                mw_en  = 1'b0;
                halted = 1'b1;
            end
            default: state_nxt = RUN;
        endcase

        // Reset fills every stage with bubbles.
        if (rst) begin
            pc_en  = 1'b1;
            fd_en  = 1'b1;
            de_en  = 1'b1;
            em_en  = 1'b1;
            mw_en  = 1'b1;
            fd_nop = 1'b1;
            de_nop = 1'b1;
            em_nop = 1'b1;
            mw_nop = 1'b1;
            halted = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            drain_cnt <= 2'd0;
            stall_cnt <= 16'd0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_nxt;
            if (state != HALTED && !pc_en && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomised and directed bench for pipe_ctrl against a rule-level reference
// model of stage enables, bubbles, halt drain and the stall counter.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0, load_use = 1'b0, br_taken = 1'b0;
    logic        imem_stall = 1'b0, dmem_stall = 1'b0, halt = 1'b0;
    logic        pc_en, fd_en, de_en, em_en, mw_en;
    logic        fd_nop, de_nop, em_nop, mw_nop, halted;
    logic [15:0] stall_cnt;
    logic [8:0]  outs;

    int vectors = 0;
    int errors  = 0;

    // Reference model: cycles of drain left (0 = not draining), halted flag, count.
    int m_drain_left = 0;
    bit m_halted     = 1'b0;
    int m_cnt        = 0;

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk(clk), .rst(rst), .load_use(load_use), .br_taken(br_taken),
        .imem_stall(imem_stall), .dmem_stall(dmem_stall), .halt(halt),
        .pc_en(pc_en), .fd_en(fd_en), .de_en(de_en), .em_en(em_en), .mw_en(mw_en),
        .fd_nop(fd_nop), .de_nop(de_nop), .em_nop(em_nop), .mw_nop(mw_nop),
        .halted(halted), .stall_cnt(stall_cnt)
    );

    assign outs = {pc_en, fd_en, de_en, em_en, mw_en, fd_nop, de_nop, em_nop, mw_nop};

    // {pc,fd,de,em,mw enables, fd,de,em,mw nops}
    function automatic logic [8:0] model_outs();
        if (rst)                   return 9'b11111_1111;
        if (m_halted)              return 9'b00000_0000;
        if (dmem_stall)            return 9'b00001_0001;
        if (m_drain_left > 0)      return 9'b01111_1000;
        if (br_taken)              return 9'b11111_1100;
        if (load_use)              return 9'b00111_0100;
        if (imem_stall)            return 9'b01111_1000;
        return 9'b11111_0000;
    endfunction

    function automatic logic model_halted();
        return m_halted && !rst;
    endfunction

    task automatic model_edge();
        logic [8:0] o;
        o = model_outs();
        if (rst) begin
            m_drain_left = 0;
            m_halted     = 1'b0;
            m_cnt        = 0;
        end else if (!m_halted) begin
            if (!o[8] && m_cnt < 65535) m_cnt++;
            if (m_drain_left > 0) begin
                if (!dmem_stall) begin
                    m_drain_left--;
                    if (m_drain_left == 0) m_halted = 1'b1;
                end
            end else if (halt && !dmem_stall && !br_taken && !load_use) begin
                m_drain_left = 3;
            end
        end
    endtask

    task automatic drive(input logic r, input logic lu, input logic br,
                         input logic im, input logic dm, input logic h);
        @(negedge clk);
        rst = r; load_use = lu; br_taken = br; imem_stall = im; dmem_stall = dm; halt = h;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            vectors++;
            if (outs !== 9'b11111_1111 || halted !== 1'b0) begin
                errors++;
                $display("FAIL reset_outs: got %b halted=%b, need 111111111 halted=0", outs, halted);
            end
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (stall_cnt !== 16'd0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: stall_cnt=%0d halted=%b, need 0 and 0", stall_cnt, halted);
        end
    endtask

    task automatic test_idle();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            vectors++;
            if (outs !== 9'b11111_0000 || halted !== 1'b0 || stall_cnt !== 16'd0) begin
                errors++;
                $display("FAIL idle: outs=%b halted=%b cnt=%0d, need 111110000 0 0", outs, halted, stall_cnt);
            end
            tick();
        end
    endtask

    task automatic test_load_use();
        logic [15:0] c0;
        c0 = stall_cnt;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (outs !== 9'b00111_0100) begin
            errors++;
            $display("FAIL load_use: outs=%b, need 001110100", outs);
        end
        tick();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (stall_cnt !== c0 + 16'd1) begin
            errors++;
            $display("FAIL load_use_cnt: cnt=%0d, need %0d", stall_cnt, c0 + 16'd1);
        end
        vectors++;
        if (outs !== 9'b11111_1100) begin
            errors++;
            $display("FAIL lu_plus_branch: outs=%b, need 111111100", outs);
        end
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (stall_cnt !== c0 + 16'd1) begin
            errors++;
            $display("FAIL branch_cnt: cnt=%0d, need %0d", stall_cnt, c0 + 16'd1);
        end
    endtask

    task automatic test_dmem_imem();
        logic [15:0] c0;
        c0 = stall_cnt;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
            vectors++;
            if (outs !== 9'b00001_0001) begin
                errors++;
                $display("FAIL dmem_imem: cycle %0d outs=%b, need 000010001", i, outs);
            end
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        vectors++;
        if (outs !== 9'b01111_1000) begin
            errors++;
            $display("FAIL imem_only: outs=%b, need 011111000", outs);
        end
        vectors++;
        if (stall_cnt !== c0 + 16'd4) begin
            errors++;
            $display("FAIL dmem_cnt: cnt=%0d, need %0d", stall_cnt, c0 + 16'd4);
        end
        tick();
    endtask

    task automatic test_halt_drain();
        logic [15:0] c0;
        int          edges;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        c0 = stall_cnt;
        vectors++;
        if (outs !== 9'b11111_0000) begin
            errors++;
            $display("FAIL halt_cycle: outs=%b, need 111110000", outs);
        end
        tick();
        edges = 1;
        for (int i = 0; i < 10 && halted !== 1'b1; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b1, (i == 1) ? 1'b1 : 1'b0, 1'b1);
            vectors++;
            if (outs !== ((i == 1) ? 9'b00001_0001 : 9'b01111_1000)) begin
                errors++;
                $display("FAIL drain_outs: cycle %0d outs=%b", i, outs);
            end
            tick();
            edges++;
        end
        vectors++;
        if (halted !== 1'b1 || edges != 5) begin
            errors++;
            $display("FAIL halt_timing: halted=%b after %0d edges, need 1 after 5", halted, edges);
        end
        vectors++;
        if (stall_cnt !== c0 + 16'd4) begin
            errors++;
            $display("FAIL drain_cnt: cnt=%0d, need %0d", stall_cnt, c0 + 16'd4);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            vectors++;
            if (outs !== 9'b0 || halted !== 1'b1 || stall_cnt !== c0 + 16'd4) begin
                errors++;
                $display("FAIL halted_hold: outs=%b halted=%b cnt=%0d", outs, halted, stall_cnt);
            end
            tick();
        end
    endtask

    task automatic test_reset_from_halted();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (halted !== 1'b0 || stall_cnt !== 16'd0 || outs !== 9'b11111_0000) begin
            errors++;
            $display("FAIL reset_halted: halted=%b cnt=%0d outs=%b, need 0 0 111110000",
                     halted, stall_cnt, outs);
        end
        tick();
    endtask

    task automatic test_random();
        logic r, lu, br, im, dm, h;
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 39) == 0);
            h  = ($urandom_range(0, 7) == 0);
            lu = ($urandom_range(0, 3) == 0);
            br = ($urandom_range(0, 3) == 0);
            im = ($urandom_range(0, 3) == 0);
            dm = ($urandom_range(0, 3) == 0);
            drive(r, lu, br, im, dm, h);
            vectors++;
            if (outs !== model_outs() || halted !== model_halted() || stall_cnt !== 16'(m_cnt)) begin
                errors++;
                $display("FAIL random: cyc %0d outs=%b halted=%b cnt=%0d, need %b %b %0d",
                         i, outs, halted, stall_cnt, model_outs(), model_halted(), m_cnt);
            end
            tick();
        end
    endtask

    task automatic test_saturate();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 65540; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            if (i == 65535) begin
                vectors++;
                if (stall_cnt !== 16'hFFFF) begin
                    errors++;
                    $display("FAIL sat_reach: cnt=%h, need ffff", stall_cnt);
                end
            end
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (stall_cnt !== 16'hFFFF || stall_cnt !== 16'(m_cnt)) begin
            errors++;
            $display("FAIL sat_hold: cnt=%h, need ffff", stall_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_load_use();
        test_dmem_imem();
        test_halt_drain();
        test_reset_from_halted();
        test_random();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
